// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the decode->execute immediate extender.
// Holds the 2-bit extension mode encodings used on in_mode.
package imm_extend_pipe_pkg;

  typedef enum logic [1:0] {
    IMM_SIGN   = 2'd0,
    IMM_ZERO   = 2'd1,
    IMM_UPPER  = 2'd2,
    IMM_BRANCH = 2'd3
  } imm_mode_e;

endpackage

// File: rtl/imm_extend_pipe_comb.sv
// Combinational immediate extension: selects sign, zero, upper (LUI) or
// branch-offset form of an IN_W-bit immediate widened to OUT_W bits.
module imm_ext_comb
  import imm_extend_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] sign_s;
  logic [OUT_W-1:0] zero_s;
  logic [OUT_W-1:0] upper_s;
  logic [OUT_W-1:0] branch_s;

  assign sign_s   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign zero_s   = {{(OUT_W-IN_W){1'b0}}, imm};
  assign upper_s  = {imm, {(OUT_W-IN_W){1'b0}}};
  // Word offset to byte offset; the two top sign copies fall off the end.
  assign branch_s = {sign_s[OUT_W-3:0], 2'b00};

  // Mode multiplexer
  always_comb begin
    ext = {OUT_W{1'b0}};
    case (mode)
      IMM_SIGN:   ext = sign_s;
      IMM_ZERO:   ext = zero_s;
      IMM_UPPER:  ext = upper_s;
      IMM_BRANCH: ext = branch_s;
      default:    ext = sign_s;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready handshakes, a one-entry
// skid buffer for full throughput under backpressure, flush and transfer counter.
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_neg,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic             main_valid_r;
  logic             skid_valid_r;
  logic             in_ready_r;
  logic [OUT_W-1:0] main_data_r;
  logic [OUT_W-1:0] skid_data_r;
  logic [TAG_W-1:0] main_tag_r;
  logic [TAG_W-1:0] skid_tag_r;
  logic [CNT_W-1:0] xfer_cnt_r;

  logic [OUT_W-1:0] ext_s;
  logic             accept_s;
  logic             emit_s;
  logic             main_valid_nxt_s;
  logic             skid_valid_nxt_s;
  logic             load_main_in_s;
  logic             load_main_skid_s;
  logic             load_skid_s;

  imm_ext_comb #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .imm  (in_imm),
    .mode (in_mode),
    .ext  (ext_s)
  );

  assign accept_s = in_valid & in_ready_r;
  assign emit_s   = main_valid_r & out_ready;

  // Next-state selection for the main/skid pair
  always_comb begin
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (emit_s) begin
      if (skid_valid_r) begin
        load_main_skid_s = 1'b1;
        skid_valid_nxt_s = 1'b0;
      end else if (accept_s) begin
        load_main_in_s   = 1'b1;
        main_valid_nxt_s = 1'b1;
      end else begin
        main_valid_nxt_s = 1'b0;
      end
    end else if (accept_s) begin
      if (main_valid_r) begin
        load_skid_s      = 1'b1;
        skid_valid_nxt_s = 1'b1;
      end else begin
        load_main_in_s   = 1'b1;
        main_valid_nxt_s = 1'b1;
      end
    end else begin
      main_valid_nxt_s = main_valid_r;
    end
  end

  // Storage registers, registered ready and transfer counter
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b0;
      main_data_r  <= {OUT_W{1'b0}};
      skid_data_r  <= {OUT_W{1'b0}};
      main_tag_r   <= {TAG_W{1'b0}};
      skid_tag_r   <= {TAG_W{1'b0}};
      xfer_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      // Ready looks only at the skid state, never at out_ready.
      in_ready_r   <= ~skid_valid_nxt_s;
      if (emit_s) begin
        xfer_cnt_r <= xfer_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (load_main_skid_s) begin
        main_data_r <= skid_data_r;
        main_tag_r  <= skid_tag_r;
      end else if (load_main_in_s) begin
        main_data_r <= ext_s;
        main_tag_r  <= in_tag;
      end
      if (load_skid_s) begin
        skid_data_r <= ext_s;
        skid_tag_r  <= in_tag;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;
  assign out_tag   = main_tag_r;
  assign out_neg   = main_data_r[OUT_W-1];
  assign xfer_cnt  = xfer_cnt_r;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed mode/backpressure/flush/reset
// scenarios plus randomized traffic against a queue-based reference model.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_neg;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_data;
  logic [15:0] xfer_cnt;

  logic        v2, rdy2, ov2, ordy2, neg2, flush2;
  logic [15:0] imm2;
  logic [1:0]  mode2;
  logic [4:0]  tag2, otag2;
  logic [31:0] od2;
  logic [3:0]  cnt2;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  t;
  } ent_t;

  imm_extend_pipe dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_neg(out_neg), .xfer_cnt(xfer_cnt)
  );

  imm_extend_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush2),
    .in_valid(v2), .in_ready(rdy2), .in_imm(imm2), .in_mode(mode2), .in_tag(tag2),
    .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .out_tag(otag2),
    .out_neg(neg2), .xfer_cnt(cnt2)
  );

  // Reference extension from plain integer arithmetic.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    longint s, r;
    s = (imm >= 16'h8000) ? (longint'(imm) - 64'sd65536) : longint'(imm);
    case (mode)
      2'd0:    r = s;
      2'd1:    r = longint'(imm);
      2'd2:    r = longint'(imm) * 64'sd65536;
      default: r = s * 64'sd4;
    endcase
    return r[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_imm = 16'h0000; in_mode = 2'd0; in_tag = 5'd0;
    flush2 = 1'b0; v2 = 1'b0; ordy2 = 1'b0; imm2 = 16'h0000; mode2 = 2'd0; tag2 = 5'd0;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    total++; if (out_tag !== 5'd0) begin bad++; $display("FAIL rst_out_tag got=%h exp=0", out_tag); end
    total++; if (xfer_cnt !== 16'd0) begin bad++; $display("FAIL rst_xfer_cnt got=%0d exp=0", xfer_cnt); end
    total++; if (cnt2 !== 4'd0) begin bad++; $display("FAIL rst_cnt4 got=%0d exp=0", cnt2); end
    reset = 1'b0;
    exp_cnt = 16'd0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_modes();
    logic [15:0] v_imm [6];
    logic [1:0]  v_mode [6];
    logic [31:0] v_exp [6];
    v_imm  = '{16'h8000, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 16'h4000};
    v_mode = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    v_exp  = '{32'hFFFF8000, 32'h00007FFF, 32'h00008000, 32'h12340000, 32'hFFFFFFFC, 32'h00010000};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_imm = v_imm[i]; in_mode = v_mode[i]; in_tag = 5'(i + 3);
      tick();
      in_valid = 1'b0; in_imm = 16'($urandom); in_mode = 2'($urandom);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mode%0d_valid got=%b exp=1", i, out_valid); end
      total++; if (out_data !== v_exp[i]) begin bad++; $display("FAIL mode%0d_data got=%h exp=%h", i, out_data, v_exp[i]); end
      total++; if (out_neg !== v_exp[i][31]) begin bad++; $display("FAIL mode%0d_neg got=%b exp=%b", i, out_neg, v_exp[i][31]); end
      total++; if (out_tag !== 5'(i + 3)) begin bad++; $display("FAIL mode%0d_tag got=%0d exp=%0d", i, out_tag, i + 3); end
      tick();
      exp_cnt = exp_cnt + 16'd1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mode%0d_drain got=%b exp=0", i, out_valid); end
    end
    total++; if (xfer_cnt !== exp_cnt) begin bad++; $display("FAIL mode_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0011; in_mode = 2'd0; in_tag = 5'd1;
    tick();
    total++; if (out_data !== 32'h00000011 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_a_load got=%h/%b exp=00000011/1", out_data, out_valid); end
    in_imm = 16'hF000; in_mode = 2'd1; in_tag = 5'd2;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_skid_ready got=%b exp=0", in_ready); end
    total++; if (out_data !== 32'h00000011 || out_tag !== 5'd1) begin bad++; $display("FAIL bp_a_hold1 got=%h/%0d exp=00000011/1", out_data, out_tag); end
    in_imm = 16'h00AB; in_mode = 2'd2; in_tag = 5'd3;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_c_stall got=%b exp=0", in_ready); end
    total++; if (out_data !== 32'h00000011 || out_tag !== 5'd1) begin bad++; $display("FAIL bp_a_hold2 got=%h/%0d exp=00000011/1", out_data, out_tag); end
    out_ready = 1'b1;
    tick();
    total++; if (out_data !== 32'h0000F000 || out_tag !== 5'd2) begin bad++; $display("FAIL bp_b_out got=%h/%0d exp=0000f000/2", out_data, out_tag); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_data !== 32'h00AB0000 || out_tag !== 5'd3 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_c_out got=%h/%0d exp=00ab0000/3", out_data, out_tag); end
    tick();
    exp_cnt = exp_cnt + 16'd3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    total++; if (xfer_cnt !== exp_cnt) begin bad++; $display("FAIL bp_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0101; in_mode = 2'd0; in_tag = 5'd4;
    tick();
    in_imm = 16'h0202; in_tag = 5'd5;
    tick();
    flush = 1'b1; in_imm = 16'h0303; in_tag = 5'd6;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_full_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_full_ready got=%b exp=1", in_ready); end
    total++; if (xfer_cnt !== exp_cnt) begin bad++; $display("FAIL fl_full_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt); end
    out_ready = 1'b1; in_valid = 1'b1; in_imm = 16'h0404; in_mode = 2'd1; in_tag = 5'd7;
    tick();
    in_valid = 1'b0;
    total++; if (out_data !== 32'h00000404 || out_tag !== 5'd7) begin bad++; $display("FAIL fl_next_entry got=%h/%0d exp=00000404/7", out_data, out_tag); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_no_ghost got=%b exp=0", out_valid); end
    out_ready = 1'b0; in_valid = 1'b1; in_imm = 16'h0505; in_mode = 2'd0; in_tag = 5'd8;
    tick();
    out_ready = 1'b1; flush = 1'b1; in_imm = 16'h0606; in_tag = 5'd9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    total++; if (xfer_cnt !== exp_cnt) begin bad++; $display("FAIL fl_emit_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt); end
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL fl_emit_state got=%b/%b exp=0/1", out_valid, in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_drop_accept got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h8888; in_mode = 2'd0; in_tag = 5'd10;
    tick();
    in_tag = 5'd11;
    tick();
    reset = 1'b1; in_valid = 1'b0;
    tick();
    exp_cnt = 16'd0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL mr_flags got=%b/%b exp=0/0", out_valid, in_ready); end
    total++; if (out_data !== 32'h0 || out_tag !== 5'd0 || out_neg !== 1'b0) begin bad++; $display("FAIL mr_data got=%h/%0d exp=0/0", out_data, out_tag); end
    total++; if (xfer_cnt !== 16'd0) begin bad++; $display("FAIL mr_cnt got=%0d exp=0", xfer_cnt); end
    reset = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mr_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1; in_valid = 1'b1; in_imm = 16'h1234; in_mode = 2'd3; in_tag = 5'd12;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 32'h000048D0) begin bad++; $display("FAIL mr_first got=%b/%h exp=1/000048d0", out_valid, out_data); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_wrap();
    int em = 0;
    v2 = 1'b1; ordy2 = 1'b1;
    for (int c = 0; c < 100 && em < 17; c++) begin
      imm2 = 16'($urandom); mode2 = 2'($urandom); tag2 = 5'($urandom);
      if (ov2) em++;
      tick();
    end
    v2 = 1'b0; ordy2 = 1'b0;
    total++; if (em !== 17) begin bad++; $display("FAIL wrap_budget got=%0d exp=17", em); end
    total++; if (cnt2 !== 4'd1) begin bad++; $display("FAIL wrap_cnt got=%0d exp=1", cnt2); end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    bit acc, em;
    for (int c = 0; c < 10000 && bad < 100; c++) begin
      in_valid  = ($urandom % 10) < 7;
      out_ready = ($urandom % 10) < 6;
      flush     = ($urandom % 64) == 0;
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom);
      in_tag    = 5'($urandom);
      total++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, q.size() > 0); end
      total++; if (in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, q.size() < 2); end
      total++; if (xfer_cnt !== exp_cnt) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, xfer_cnt, exp_cnt); end
      if (q.size() > 0) begin
        e = q[0];
        total++; if (out_data !== e.d || out_tag !== e.t) begin bad++; $display("FAIL rnd_data c=%0d got=%h/%0d exp=%h/%0d", c, out_data, out_tag, e.d, e.t); end
        total++; if (out_neg !== e.d[31]) begin bad++; $display("FAIL rnd_neg c=%0d got=%b exp=%b", c, out_neg, e.d[31]); end
      end
      acc = in_valid && (q.size() < 2);
      em  = (q.size() > 0) && out_ready;
      e.d = ref_ext(in_imm, in_mode);
      e.t = in_tag;
      @(posedge clk);
      if (em) begin
        void'(q.pop_front());
        exp_cnt = exp_cnt + 16'd1;
      end
      if (flush) q.delete();
      else if (acc) q.push_back(e);
      @(negedge clk);
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
